// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, default word/tick sizing and
// the frame length the arbiter timeout has to exceed.
package uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LAUNCH = 2'd1,
    ARB_WAIT   = 2'd2,
    ARB_GAP    = 2'd3
  } arb_state_t;

  localparam int UART_NBITS = 8;
  localparam int UART_NTICK = 16;

  // Ticks from tx_ena to tx_done for one frame; TMO must exceed FRAME_TICKS + 2.
  localparam int FRAME_TICKS = UART_NTICK * (UART_NBITS + 1) + 2 * UART_NTICK;

endpackage

// File: rtl/tx_arbiter_if.sv
// Producer/transmitter side signals of the transmit arbiter. The master modport is
// the arbiter; the slave modport is whatever drives the requests and tx_done.
interface tx_arbiter_if import uart_pkg::*; #(
  parameter int NREQ  = 4,
  parameter int NBITS = UART_NBITS
);
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*NBITS-1:0] req_data;
  logic                  tx_done;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  tx_ena;
  logic [NBITS-1:0]      tx_data;
  logic [OW-1:0]         owner;
  logic                  busy;
  logic                  tmo_err;

  modport master (
    input  req, req_data, tx_done,
    output grant, done, tx_ena, tx_data, owner, busy, tmo_err
  );

  modport slave (
    output req, req_data, tx_done,
    input  grant, done, tx_ena, tx_data, owner, busy, tmo_err
  );
endinterface

// File: rtl/tx_arbiter_rr_pick.sv
// Combinational round-robin select: the first set request found scanning upward
// from pointer (modulo NREQ).
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   pointer,
  output logic [PW-1:0]   index,
  output logic            valid
);

  function automatic int slot_of(input int base, input int offset);
    return (base + offset) % NREQ;
  endfunction

  // Scan from the farthest offset back toward pointer so the closest request wins.
  always_comb begin
    index = {PW{1'b0}};
    valid = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      valid = valid | req[slot_of(int'(pointer), i)];
      index = req[slot_of(int'(pointer), i)] ? PW'(slot_of(int'(pointer), i)) : index;
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte producers,
// with completion timeout and a fixed inter-frame gap.
module tx_arbiter import uart_pkg::*; #(
  parameter int NREQ  = 4,
  parameter int NBITS = UART_NBITS,
  parameter int TMO   = 256,
  parameter int IFG   = 4
) (
  input logic          bdtick,
  input logic          arb_rst,
  tx_arbiter_if.master bus
);

  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TMO) + 1;
  localparam int GW = $clog2(IFG) + 1;
  localparam logic [TW-1:0]   TMO_LAST = TW'(TMO - 1);
  localparam logic [GW-1:0]   IFG_LAST = GW'(IFG - 1);
  localparam logic [PW-1:0]   PTR_MAX  = PW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_LSB  = {{(NREQ-1){1'b0}}, 1'b1};

  arb_state_t       state_r;
  logic [PW-1:0]    ptr_r;
  logic [PW-1:0]    owner_r;
  logic [TW-1:0]    wcnt_r;
  logic [GW-1:0]    gcnt_r;
  logic [NREQ-1:0]  grant_r;
  logic [NREQ-1:0]  done_r;
  logic             tx_ena_r;
  logic [NBITS-1:0] tx_data_r;
  logic             busy_r;
  logic             tmo_err_r;
  logic [PW-1:0]    pick_idx_s;
  logic             pick_vld_s;
  logic [PW-1:0]    ptr_next_s;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (bus.req),
    .pointer (ptr_r),
    .index   (pick_idx_s),
    .valid   (pick_vld_s)
  );

  assign ptr_next_s = (owner_r == PTR_MAX) ? {PW{1'b0}} : owner_r + PW'(1);

  // Arbitration FSM; every output is a register written here.
  always_ff @(posedge bdtick or negedge arb_rst) begin
    if (!arb_rst) begin
      state_r   <= ARB_IDLE;
      ptr_r     <= {PW{1'b0}};
      owner_r   <= {PW{1'b0}};
      wcnt_r    <= {TW{1'b0}};
      gcnt_r    <= {GW{1'b0}};
      grant_r   <= {NREQ{1'b0}};
      done_r    <= {NREQ{1'b0}};
      tx_ena_r  <= 1'b0;
      tx_data_r <= {NBITS{1'b0}};
      busy_r    <= 1'b0;
      tmo_err_r <= 1'b0;
    end else begin
      grant_r  <= {NREQ{1'b0}};
      done_r   <= {NREQ{1'b0}};
      tx_ena_r <= 1'b0;
      case (state_r)
        ARB_IDLE: begin
          if (pick_vld_s) begin
            grant_r   <= ONE_LSB << pick_idx_s;
            tx_data_r <= bus.req_data[int'(pick_idx_s) * NBITS +: NBITS];
            owner_r   <= pick_idx_s;
            busy_r    <= 1'b1;
            state_r   <= ARB_LAUNCH;
          end
        end
        ARB_LAUNCH: begin
          tx_ena_r <= 1'b1;
          wcnt_r   <= {TW{1'b0}};
          state_r  <= ARB_WAIT;
        end
        ARB_WAIT: begin
          // tx_done takes priority over a timeout landing on the same clock.
          if (bus.tx_done || (wcnt_r == TMO_LAST)) begin
            done_r  <= ONE_LSB << owner_r;
            ptr_r   <= ptr_next_s;
            gcnt_r  <= {GW{1'b0}};
            state_r <= ARB_GAP;
            if (!bus.tx_done) begin
              tmo_err_r <= 1'b1;
            end
          end else begin
            wcnt_r <= wcnt_r + TW'(1);
          end
        end
        ARB_GAP: begin
          if (gcnt_r == IFG_LAST) begin
            busy_r  <= 1'b0;
            state_r <= ARB_IDLE;
          end else begin
            gcnt_r <= gcnt_r + GW'(1);
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.grant   = grant_r;
  assign bus.done    = done_r;
  assign bus.tx_ena  = tx_ena_r;
  assign bus.tx_data = tx_data_r;
  assign bus.owner   = owner_r;
  assign bus.busy    = busy_r;
  assign bus.tmo_err = tmo_err_r;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: directed scenarios then random traffic, every cycle checked
// against a timeline model built from clock-edge arithmetic.
module tb_tx_arbiter;
  import uart_pkg::*;

  localparam int NREQ  = 4;
  localparam int NBITS = 8;
  localparam int TMO   = 256;
  localparam int IFG   = 4;

  logic bdtick  = 1'b0;
  logic arb_rst = 1'b1;

  tx_arbiter_if #(.NREQ(NREQ), .NBITS(NBITS)) bus ();

  tx_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .TMO(TMO), .IFG(IFG)) dut (
    .bdtick  (bdtick),
    .arb_rst (arb_rst),
    .bus     (bus)
  );

  always #5 bdtick = ~bdtick;

  int checks   = 0;
  int failures = 0;
  int n        = 0;

  logic [NREQ-1:0]       req_v;
  logic [NREQ*NBITS-1:0] data_v;
  logic                  tx_done_v;
  bit rand_on, spur_on, hold_all;
  int dly_mode, dly_fix, plan_edge;

  // Model: a frame is a grant edge, tx_ena one edge later, done at the first
  // tx_done edge after that (or TMO edges after tx_ena), idle IFG edges after done.
  bit               m_active;
  int               m_ptr, m_ena_edge, m_done_edge;
  logic [NREQ-1:0]  e_grant, e_done;
  logic [NBITS-1:0] e_data;
  int               e_owner;
  bit               e_ena, e_busy, e_tmo;
  int               glog[$];
  int               g_edge, d_edge, b_edge;
  bit               d_tmo;
  logic [NBITS-1:0] g_data;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", nm, n, got, exp);
    end
  endtask

  task automatic m_reset();
    m_active = 1'b0; m_ptr = 0; m_ena_edge = -10; m_done_edge = -1;
    e_grant = '0; e_done = '0; e_data = '0; e_owner = 0;
    e_ena = 1'b0; e_busy = 1'b0; e_tmo = 1'b0; plan_edge = -1;
  endtask

  task automatic m_finish(input bit timed_out);
    e_done[e_owner] = 1'b1;
    m_done_edge = n;
    m_ptr = (e_owner + 1) % NREQ;
    if (timed_out) e_tmo = 1'b1;
    d_edge = n; d_tmo = timed_out; plan_edge = -1;
  endtask

  task automatic model_step();
    int k;
    k = -1;
    e_grant = '0; e_done = '0;
    e_ena = m_active && (n == m_ena_edge);
    if (!m_active) begin
      for (int i = 0; i < NREQ; i++)
        if (k < 0 && req_v[(m_ptr + i) % NREQ]) k = (m_ptr + i) % NREQ;
      if (k >= 0) begin
        e_owner = k; e_data = data_v[k*NBITS +: NBITS]; e_grant[k] = 1'b1;
        m_active = 1'b1; m_ena_edge = n + 1; m_done_edge = -1; e_busy = 1'b1;
        glog.push_back(k); g_edge = n; g_data = e_data;
        case (dly_mode)
          0: plan_edge = n + 1 + dly_fix;
          1: plan_edge = -1;
          default: begin
            k = $urandom_range(0, 31);
            if (k == 0) plan_edge = -1;
            else if (k < 3) plan_edge = n + 1 + $urandom_range(150, TMO);
            else plan_edge = n + 1 + $urandom_range(1, 40);
          end
        endcase
      end
    end else if (m_done_edge < 0) begin
      if (n > m_ena_edge) begin
        if (tx_done_v) m_finish(1'b0);
        else if (n - m_ena_edge == TMO) m_finish(1'b1);
      end
    end else if (n == m_done_edge + IFG) begin
      m_active = 1'b0; e_busy = 1'b0; b_edge = n;
    end
  endtask

  task automatic compare_all();
    chk("grant",   bus.grant,   e_grant);
    chk("done",    bus.done,    e_done);
    chk("tx_ena",  bus.tx_ena,  e_ena);
    chk("tx_data", bus.tx_data, e_data);
    chk("owner",   bus.owner,   e_owner);
    chk("busy",    bus.busy,    e_busy);
    chk("tmo_err", bus.tmo_err, e_tmo);
  endtask

  task automatic cycle();
    int nx;
    bit waiting;
    nx = n + 1;
    waiting = m_active && (m_done_edge < 0) && (nx > m_ena_edge);
    if (waiting) tx_done_v = (nx == plan_edge);
    else tx_done_v = spur_on && ($urandom_range(0, 7) == 0);
    bus.req = req_v; bus.req_data = data_v; bus.tx_done = tx_done_v;
    @(posedge bdtick);
    n = nx;
    if (!arb_rst) m_reset();
    else model_step();
    #1;
    compare_all();
    req_v = req_v & ~e_grant;
    if (hold_all) req_v = {NREQ{1'b1}};
    if (rand_on) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_v[i] && !e_grant[i] && ($urandom_range(0, 3) == 0)) req_v[i] = 1'b1;
        data_v[i*NBITS +: NBITS] = NBITS'($urandom());
      end
    end
  endtask

  task automatic run_idle(input int max);
    int c;
    c = 0;
    do begin cycle(); c++; end while ((m_active || req_v != '0) && c < max);
    checks++;
    if (m_active || req_v != '0) begin
      failures++;
      $display("FAIL run_idle_bound edge=%0d got=%0d cycles exp=idle", n, c);
    end
  endtask

  task automatic do_reset();
    arb_rst = 1'b0;
    #1;
    m_reset();
    chk("rst_grant", bus.grant, 64'd0);   chk("rst_done", bus.done, 64'd0);
    chk("rst_tx_ena", bus.tx_ena, 64'd0); chk("rst_tx_data", bus.tx_data, 64'd0);
    chk("rst_owner", bus.owner, 64'd0);   chk("rst_busy", bus.busy, 64'd0);
    chk("rst_tmo_err", bus.tmo_err, 64'd0);
    cycle();
    arb_rst = 1'b1;
  endtask

  initial begin
    int c, s;
    m_reset();
    req_v = '0; data_v = '0; tx_done_v = 1'b0;
    rand_on = 1'b0; spur_on = 1'b0; hold_all = 1'b0; dly_mode = 0; dly_fix = 20;
    bus.req = '0; bus.req_data = '0; bus.tx_done = 1'b0;
    #2;
    do_reset();

    // Round robin from pointer 0 with everyone requesting.
    glog.delete(); hold_all = 1'b1; req_v = {NREQ{1'b1}}; c = 0;
    while (glog.size() < 5 && c < 3000) begin cycle(); c++; end
    hold_all = 1'b0; req_v = '0;
    run_idle(1000);
    chk("rr_count", glog.size(), 64'd5);
    if (glog.size() >= 5) begin
      chk("rr_0", glog[0], 64'd0); chk("rr_1", glog[1], 64'd1); chk("rr_2", glog[2], 64'd2);
      chk("rr_3", glog[3], 64'd3); chk("rr_4", glog[4], 64'd0);
    end

    // Single request, tx_done 200 clocks after tx_ena.
    glog.delete(); dly_fix = 200;
    data_v[2*NBITS +: NBITS] = 8'hA5; req_v = 4'b0100; s = n;
    run_idle(1000);
    chk("single_idx", glog.size() > 0 ? glog[0] : -1, 64'd2);
    chk("single_lat", g_edge - s, 64'd1);
    chk("single_data", g_data, 64'hA5);
    chk("single_done", d_edge - g_edge, 64'd201);
    chk("single_busy", b_edge - d_edge, IFG);

    // Pointer sits at 3 after requester 2.
    glog.delete(); dly_fix = 7; req_v = 4'b1001;
    run_idle(1000);
    chk("wrap_count", glog.size(), 64'd2);
    if (glog.size() >= 2) begin
      chk("wrap_0", glog[0], 64'd3); chk("wrap_1", glog[1], 64'd0);
    end

    // tx_done on the last allowed WAIT clock.
    dly_fix = TMO; req_v = 4'b0001;
    run_idle(2000);
    chk("coin_done", d_edge - g_edge, TMO + 1);
    chk("coin_tmo", d_tmo, 64'd0);

    // Transmitter never answers.
    dly_mode = 1; req_v = 4'b0010;
    run_idle(2000);
    chk("tmo_done", d_edge - (g_edge + 1), 64'd256);
    chk("tmo_flag", d_tmo, 64'd1);
    dly_mode = 0; dly_fix = 10; req_v = 4'b0001;
    run_idle(1000);
    chk("tmo_sticky", e_tmo, 64'd1);

    // Reset in WAIT with pointer at 1; requests 0 and 1 pending.
    dly_mode = 1; req_v = 4'b0010;
    repeat (12) cycle();
    req_v = req_v | 4'b0011;
    repeat (3) cycle();
    do_reset();
    glog.delete(); dly_mode = 0; dly_fix = 5;
    run_idle(1000);
    chk("rst_regrant", glog.size() > 0 ? glog[0] : -1, 64'd0);

    // Random traffic, spurious tx_done outside WAIT, one reset in the middle.
    rand_on = 1'b1; spur_on = 1'b1; dly_mode = 2;
    for (int it = 0; it < 20000; it++) begin
      if (it == 9000) do_reset();
      else cycle();
    end
    rand_on = 1'b0; spur_on = 1'b0; dly_mode = 0; dly_fix = 3;
    run_idle(5000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog edge=%0d got=running exp=finished", n);
    $fatal(1, "watchdog expired");
  end

endmodule
